// File: rtl/mips_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mips_lsu                                                      |
// | Load/store unit: word-aligned data-port access with lane formatting.   |
// | Option : LSU_UNALIGNED_EN enables LWL/LWR (ops 5/6).                   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module mips_lsu #(
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dp_address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        read_dp,
    output logic        write_dp,
    input  logic [31:0] dp_readdata,
    input  logic        stall
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
`ifdef LSU_UNALIGNED_EN
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
`endif
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        w_req_legal;
    logic        w_req_misalign;
    logic        w_req_bad;
    logic        w_timeout;
    logic [1:0]  w_k;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

`ifdef LSU_UNALIGNED_EN
    logic [31:0] rt_q, rt_d;
    logic [4:0]  w_lwl_shl;
    logic [4:0]  w_lwr_shr;
`else
    logic        w_unused_rt;
    assign w_unused_rt = ^req_rt_old;
`endif

    // Request classification; only ever feeds registers, never the memory side.
    always_comb begin
        w_req_legal    = 1'b0;
        w_req_misalign = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: w_req_legal = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                w_req_legal    = 1'b1;
                w_req_misalign = req_addr[0];
            end
            OP_LW, OP_SW: begin
                w_req_legal    = 1'b1;
                w_req_misalign = |req_addr[1:0];
            end
`ifdef LSU_UNALIGNED_EN
            OP_LWL, OP_LWR: w_req_legal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign w_req_bad = !w_req_legal || w_req_misalign;

    always_comb begin
        w_timeout = 1'b0;
        if (STALL_TIMEOUT != 0) begin
            w_timeout = stall && ((cnt_q + 32'd1) == STALL_TIMEOUT);
        end
    end

    assign w_k    = addr_q[1:0];
    assign w_byte = dp_readdata[{w_k, 3'b000} +: 8];
    assign w_half = dp_readdata[{w_k[1], 4'b0000} +: 16];
`ifdef LSU_UNALIGNED_EN
    assign w_lwl_shl = {2'd3 - w_k, 3'b000};
    assign w_lwr_shr = {w_k, 3'b000};
`endif

    always_comb begin
        w_load_data = 32'h0;
        case (op_q)
            OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_load_data = {24'h0, w_byte};
            OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU: w_load_data = {16'h0, w_half};
            OP_LW:  w_load_data = dp_readdata;
`ifdef LSU_UNALIGNED_EN
            // Memory lanes k..0 land in the top bytes; untouched bytes keep rt.
            OP_LWL: w_load_data = (dp_readdata << w_lwl_shl)
                                | (rt_q & ~(32'hFFFF_FFFF << w_lwl_shl));
            OP_LWR: w_load_data = (dp_readdata >> w_lwr_shr)
                                | (rt_q & ~(32'hFFFF_FFFF >> w_lwr_shr));
`endif
            default: w_load_data = 32'h0;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (op_q)
            OP_LB, OP_LBU: w_be = 4'b0001 << w_k;
            OP_LH, OP_LHU: w_be = 4'b0011 << w_k;
            OP_LW:         w_be = 4'b1111;
`ifdef LSU_UNALIGNED_EN
            OP_LWL:        w_be = 4'b1111 >> (2'd3 - w_k);
            OP_LWR:        w_be = 4'b1111 << w_k;
`endif
            OP_SB: begin
                w_be    = 4'b0001 << w_k;
                w_wdata = {4{wdata_q[7:0]}};
            end
            OP_SH: begin
                w_be    = 4'b0011 << w_k;
                w_wdata = {2{wdata_q[15:0]}};
            end
            OP_SW: begin
                w_be    = 4'b1111;
                w_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = w_req_bad ? S_RESP : S_ACCESS;
            S_ACCESS: if (!stall || w_timeout) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef LSU_UNALIGNED_EN
        rt_d    = rt_q;
`endif
        if (state_q == S_IDLE && req_valid) begin
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            rdata_d = 32'h0;
            err_d   = w_req_bad;
            cnt_d   = 32'h0;
`ifdef LSU_UNALIGNED_EN
            rt_d    = req_rt_old;
`endif
        end else if (state_q == S_ACCESS) begin
            if (!stall) begin
                rdata_d = op_q[3] ? 32'h0 : w_load_data;
                err_d   = 1'b0;
            end else if (w_timeout) begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
            end else begin
                cnt_d   = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0;
`ifdef LSU_UNALIGNED_EN
            rt_q    <= 32'h0;
`endif
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef LSU_UNALIGNED_EN
            rt_q    <= rt_d;
`endif
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        read_dp    = 1'b0;
        write_dp   = 1'b0;
        dp_address = 32'h0;
        byteenable = 4'b0000;
        writedata  = 32'h0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_ACCESS: begin
                read_dp    = !op_q[3];
                write_dp   = op_q[3];
                dp_address = {addr_q[31:2], 2'b00};
                byteenable = w_be;
                writedata  = w_wdata;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mips_lsu                                                   |
// | Directed table-driven bench for mips_lsu with a small data memory.     |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_mips_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_rt_old = 32'h0;
    logic        stall = 1'b0;

    logic        req_ready, resp_valid, resp_err, read_dp, write_dp;
    logic [31:0] resp_rdata, dp_address, writedata, dp_readdata;
    logic [3:0]  byteenable;
    logic        req_ready_t, resp_valid_t, resp_err_t, read_dp_t, write_dp_t;
    logic [31:0] resp_rdata_t, dp_address_t, writedata_t, dp_readdata_t;
    logic [3:0]  byteenable_t;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_lsu u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rt_old(req_rt_old), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dp_address(dp_address), .writedata(writedata),
        .byteenable(byteenable), .read_dp(read_dp), .write_dp(write_dp),
        .dp_readdata(dp_readdata), .stall(stall)
    );

    mips_lsu #(.STALL_TIMEOUT(2)) u_dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_t),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rt_old(req_rt_old), .resp_valid(resp_valid_t), .resp_rdata(resp_rdata_t),
        .resp_err(resp_err_t), .dp_address(dp_address_t), .writedata(writedata_t),
        .byteenable(byteenable_t), .read_dp(read_dp_t), .write_dp(write_dp_t),
        .dp_readdata(dp_readdata_t), .stall(stall)
    );

    logic [31:0] mem [0:15];
    assign dp_readdata   = read_dp   ? mem[dp_address[5:2]]   : 32'h0;
    assign dp_readdata_t = read_dp_t ? mem[dp_address_t[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h4433_2211;
            mem[4] <= 32'h8899_AABB;
        end else if (write_dp && !stall) begin
            for (int l = 0; l < 4; l++)
                if (byteenable[l]) mem[dp_address[5:2]][8*l +: 8] <= writedata[8*l +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] da;
        logic [31:0] wd;
        int          rd;
        int          wr;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rt, input logic [31:0] rdata, input logic err,
                       input logic [3:0] be, input logic [31:0] wd, input int rd, input int wr);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rt = rt; v.rdata = rdata; v.err = err;
        v.be = be; v.da = {addr[31:2], 2'b00}; v.wd = wd; v.rd = rd; v.wr = wr;
        v.lat = err ? 1 : 2;
        tbl.push_back(v);
    endtask

    // One request; stall is held high for ns access cycles.
    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rt, input int ns,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int rd_cyc, output int wr_cyc, output logic [3:0] be,
                           output logic [31:0] da, output logic [31:0] wdo, output logic stable,
                           output int n_resp, output logic [31:0] rdata_t, output logic err_t,
                           output int n_resp_t);
        int   acc;
        logic first;
        @(negedge clk);
        chk("req_ready before request", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
        stall = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; rd_cyc = 0; wr_cyc = 0; be = 4'h0; da = 32'h0; wdo = 32'h0; stable = 1'b1;
        first = 1'b1; acc = 0; n_resp = 0; n_resp_t = 0; rdata = 32'h0; err = 1'b0;
        rdata_t = 32'h0; err_t = 1'b0;
        while (n_resp == 0 && lat < 40) begin
            if (resp_valid_t) begin
                n_resp_t++; rdata_t = resp_rdata_t; err_t = resp_err_t;
            end
            if (resp_valid) begin
                n_resp++; rdata = resp_rdata; err = resp_err;
            end else begin
                if (read_dp || write_dp) begin
                    if (first) begin
                        be = byteenable; da = dp_address; wdo = writedata; first = 1'b0;
                    end else if (be !== byteenable || da !== dp_address || wdo !== writedata) begin
                        stable = 1'b0;
                    end
                    rd_cyc += int'(read_dp);
                    wr_cyc += int'(write_dp);
                    stall = (acc < ns);
                    acc++;
                end
                @(negedge clk);
                lat++;
            end
        end
        stall = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_resp   += int'(resp_valid);
            n_resp_t += int'(resp_valid_t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata, da, wdo, rdata_t;
        logic        err, stable, err_t;
        logic [3:0]  be;
        int          lat, rd_cyc, wr_cyc, n_resp, n_resp_t;

        //  op     addr      wdata      rt         rdata      err   be       wd        rd wr
        add(4'd0,  32'h11, 32'h0,       32'h0,     32'hFFFFFFAA, 1'b0, 4'b0010, 32'h0,       1, 0);
        add(4'd1,  32'h10, 32'h0,       32'h0,     32'h000000BB, 1'b0, 4'b0001, 32'h0,       1, 0);
        add(4'd3,  32'h12, 32'h0,       32'h0,     32'h00008899, 1'b0, 4'b1100, 32'h0,       1, 0);
        add(4'd2,  32'h10, 32'h0,       32'h0,     32'hFFFFAABB, 1'b0, 4'b0011, 32'h0,       1, 0);
        add(4'd0,  32'h13, 32'h0,       32'h0,     32'hFFFFFF88, 1'b0, 4'b1000, 32'h0,       1, 0);
        add(4'd2,  32'h13, 32'h0,       32'h0,     32'h0,        1'b1, 4'b0000, 32'h0,       0, 0);
        add(4'd8,  32'h22, 32'h123456CC, 32'h0,    32'h0,        1'b0, 4'b0100, 32'hCCCCCCCC, 0, 1);
        add(4'd4,  32'h20, 32'h0,       32'h0,     32'h00CC0000, 1'b0, 4'b1111, 32'h0,       1, 0);
        add(4'd9,  32'h20, 32'h0000BEEF, 32'h0,    32'h0,        1'b0, 4'b0011, 32'hBEEFBEEF, 0, 1);
        add(4'd4,  32'h20, 32'h0,       32'h0,     32'h00CCBEEF, 1'b0, 4'b1111, 32'h0,       1, 0);
        add(4'd10, 32'h24, 32'hDEADBEEF, 32'h0,    32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 0, 1);
        add(4'd4,  32'h24, 32'h0,       32'h0,     32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,       1, 0);
        add(4'd4,  32'h22, 32'h0,       32'h0,     32'h0,        1'b1, 4'b0000, 32'h0,       0, 0);
        add(4'd9,  32'h21, 32'h1234,    32'h0,     32'h0,        1'b1, 4'b0000, 32'h0,       0, 0);
        add(4'd7,  32'h10, 32'h0,       32'h0,     32'h0,        1'b1, 4'b0000, 32'h0,       0, 0);
        add(4'd15, 32'h10, 32'h0,       32'h0,     32'h0,        1'b1, 4'b0000, 32'h0,       0, 0);
`ifdef LSU_UNALIGNED_EN
        add(4'd5,  32'h1,  32'h0,       32'hAABBCCDD, 32'h2211CCDD, 1'b0, 4'b0011, 32'h0,    1, 0);
        add(4'd6,  32'h1,  32'h0,       32'hAABBCCDD, 32'hAA443322, 1'b0, 4'b1110, 32'h0,    1, 0);
        add(4'd5,  32'h0,  32'h0,       32'hAABBCCDD, 32'h11BBCCDD, 1'b0, 4'b0001, 32'h0,    1, 0);
        add(4'd6,  32'h3,  32'h0,       32'hAABBCCDD, 32'hAABBCC44, 1'b0, 4'b1000, 32'h0,    1, 0);
`else
        add(4'd5,  32'h1,  32'h0,       32'hAABBCCDD, 32'h0,     1'b1, 4'b0000, 32'h0,       0, 0);
        add(4'd6,  32'h1,  32'h0,       32'hAABBCCDD, 32'h0,     1'b1, 4'b0000, 32'h0,       0, 0);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_err",   {31'd0, resp_err},   32'd0);
        chk("reset resp_rdata", resp_rdata,          32'd0);
        chk("reset read_dp",    {31'd0, read_dp},    32'd0);
        chk("reset write_dp",   {31'd0, write_dp},   32'd0);
        chk("reset byteenable", {28'd0, byteenable}, 32'd0);
        chk("reset dp_address", dp_address,          32'd0);
        chk("reset writedata",  writedata,           32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready after reset", {31'd0, req_ready}, 32'd1);

        foreach (tbl[i]) begin
            run_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rt, 0,
                    rdata, err, lat, rd_cyc, wr_cyc, be, da, wdo, stable, n_resp,
                    rdata_t, err_t, n_resp_t);
            chk($sformatf("v%0d rdata", i),   rdata, tbl[i].rdata);
            chk($sformatf("v%0d err", i),     {31'd0, err}, {31'd0, tbl[i].err});
            chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d read cycles", i),  rd_cyc, tbl[i].rd);
            chk($sformatf("v%0d write cycles", i), wr_cyc, tbl[i].wr);
            chk($sformatf("v%0d resp count", i),   n_resp, 1);
            if (tbl[i].rd + tbl[i].wr > 0) begin
                chk($sformatf("v%0d byteenable", i), {28'd0, be}, {28'd0, tbl[i].be});
                chk($sformatf("v%0d dp_address", i), da, tbl[i].da);
                chk($sformatf("v%0d writedata", i),  wdo, tbl[i].wd);
            end
        end

        // LW with three stall cycles; the timeout instance aborts after two.
        run_req(4'd4, 32'h10, 32'h0, 32'h0, 3,
                rdata, err, lat, rd_cyc, wr_cyc, be, da, wdo, stable, n_resp,
                rdata_t, err_t, n_resp_t);
        chk("stall rdata",        rdata, 32'h8899AABB);
        chk("stall err",          {31'd0, err}, 32'd0);
        chk("stall latency",      lat, 5);
        chk("stall read cycles",  rd_cyc, 4);
        chk("stall stable",       {31'd0, stable}, 32'd1);
        chk("stall dp_address",   da, 32'h10);
        chk("stall resp count",   n_resp, 1);
        chk("timeout err",        {31'd0, err_t}, 32'd1);
        chk("timeout rdata",      rdata_t, 32'd0);
        chk("timeout resp count", n_resp_t, 1);

        // Reset while in ACCESS abandons the access without a response.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd4; req_addr = 32'h10; stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst read_dp in access", {31'd0, read_dp}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst read_dp",    {31'd0, read_dp},    32'd0);
        chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst read_dp t",  {31'd0, read_dp_t},  32'd0);
        rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("midrst req_ready",   {31'd0, req_ready},  32'd1);
        chk("midrst resp_valid2", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("midrst resp_valid3", {31'd0, resp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
